// File: rtl/div_pkg.sv
// Shared definitions for the 8/4-bit sequential restoring divider.
package div_pkg;
    localparam int DIV_ITER = 8;
    localparam int DVD_W    = 8;
    localparam int DVS_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor from a 5-bit partial remainder.
module div_step
    import div_pkg::*;
(
    input  logic [DVS_W:0]   pr,
    input  logic [DVS_W-1:0] dvs,
    output logic [DVS_W-1:0] rem,
    output logic             qbit
);
    logic [DVS_W:0] diff;

    assign diff = pr - {1'b0, dvs};
    assign qbit = (pr >= {1'b0, dvs});
    // The true remainder is always below the divisor, so 4 bits never truncate a valid result.
    assign rem  = qbit ? diff[DVS_W-1:0] : pr[DVS_W-1:0];
endmodule

// File: rtl/div8_4_seq.sv
// Sequential 8-bit / 4-bit unsigned restoring divider, one quotient bit per cycle.
// Optional DIV_BYZERO_EN adds the dz port and a one-cycle short cut for a zero divisor.
module div8_4_seq
    import div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
`ifdef DIV_BYZERO_EN
    output logic       dz,
`endif
    output logic [7:0] q,
    output logic [3:0] r
);
    state_t state_reg, state_next;

    logic [DVD_W-1:0] dvd_reg;
    logic [DVD_W-1:0] quo_reg;
    logic [DVS_W-1:0] dvs_reg;
    logic [DVS_W-1:0] rem_reg;
    logic [2:0]       cnt_reg;
    logic [DVD_W-1:0] q_reg;
    logic [DVS_W-1:0] r_reg;

    logic             accept;
    logic             last;
    logic             zero_skip;
    logic [DVS_W-1:0] rem_step;
    logic             qbit;
    logic [DVD_W-1:0] quo_step;

    assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last     = (cnt_reg == 3'(DIV_ITER - 1));
    assign quo_step = {quo_reg[DVD_W-2:0], qbit};

`ifdef DIV_BYZERO_EN
    logic dz_reg;
    assign zero_skip = (state_reg == RUN) && (dvs_reg == '0);
    assign dz        = dz_reg;
`else
    assign zero_skip = 1'b0;
`endif

    div_step u_step (
        .pr   ({rem_reg, dvd_reg[DVD_W-1]}),
        .dvs  (dvs_reg),
        .rem  (rem_step),
        .qbit (qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (zero_skip || last) state_next = DONE;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_reg <= '0;
            dvs_reg <= '0;
            rem_reg <= '0;
            quo_reg <= '0;
            cnt_reg <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
`ifdef DIV_BYZERO_EN
            dz_reg  <= 1'b0;
`endif
        end else if (accept) begin
            dvd_reg <= a;
            dvs_reg <= b;
            rem_reg <= '0;
            quo_reg <= '0;
            cnt_reg <= '0;
`ifdef DIV_BYZERO_EN
            dz_reg  <= 1'b0;
`endif
        end else if (state_reg == RUN) begin
            if (zero_skip) begin
                // Operands are untouched in the first RUN cycle, so dvd_reg still holds a.
                q_reg   <= '1;
                r_reg   <= dvd_reg[DVS_W-1:0];
`ifdef DIV_BYZERO_EN
                dz_reg  <= 1'b1;
`endif
            end else begin
                dvd_reg <= {dvd_reg[DVD_W-2:0], 1'b0};
                rem_reg <= rem_step;
                quo_reg <= quo_step;
                cnt_reg <= last ? cnt_reg : cnt_reg + 3'd1;
                if (last) begin
                    q_reg <= quo_step;
                    r_reg <= rem_step;
                end
            end
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign q    = q_reg;
    assign r    = r_reg;
endmodule

// File: tb/tb_div8_4_seq.sv
// Scoreboard bench for div8_4_seq: driver queues expected results, a negedge monitor checks each done.
module tb_div8_4_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [3:0] b;
    logic       busy, done;
    logic [7:0] q;
    logic [3:0] r;
`ifdef DIV_BYZERO_EN
    logic       dz;
`endif

    div8_4_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
`ifdef DIV_BYZERO_EN
        .dz    (dz),
`endif
        .q     (q),
        .r     (r)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned q;
        int unsigned r;
        int unsigned dz;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge: raise start so it is sampled at the next rising edge.
    task automatic issue(input int unsigned av, input int unsigned bv);
        exp_t e;
        int   lat;
        lat = 8;
`ifdef DIV_BYZERO_EN
        if (bv == 0) lat = 1;
`endif
        e.a   = av;
        e.b   = bv;
        e.q   = (bv == 0) ? 255 : av / bv;
        e.r   = (bv == 0) ? (av % 16) : av % bv;
        e.dz  = (bv == 0) ? 1 : 0;
        e.due = cyc + 1 + lat;
        sb.push_back(e);
        a = av[7:0];
        b = bv[3:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", int'(busy), 1);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drain", sb.size(), 0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done_seen", int'(done), 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("q", int'(q), int'(e.q));
                check("r", int'(r), int'(e.r));
                check("done_latency", cyc, e.due);
                check("busy_in_done", int'(busy), 0);
`ifdef DIV_BYZERO_EN
                check("dz", int'(dz), int'(e.dz));
`endif
                $display("div a=%0d b=%0d -> q=%0d r=%0d at cycle %0d", e.a, e.b, q, r, cyc);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_q", int'(q), 0);
        check("reset_r", int'(r), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, including the zero divisor.
        issue(200, 7);  wait_empty();
        issue(255, 15); wait_empty();
        issue(5, 9);    wait_empty();
        issue(100, 0);  wait_empty();

        // Start mid-run is ignored; then a back-to-back start in the DONE cycle.
        issue(200, 7);
        repeat (3) @(negedge clk);
        a = 8'd9; b = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_mid_run", int'(busy), 1);
        wait_done();
        issue(9, 3);
        wait_empty();

        // Reset in the middle of a run aborts it.
        issue(200, 7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_q", int'(q), 0);
        check("abort_r", int'(r), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_done_after_abort", int'(done), 0);

        // Randomised traffic with occasional back-to-back starts.
        for (int n = 0; n < 60; n++) begin
            int unsigned av, bv;
            av = $urandom_range(0, 255);
            bv = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
            issue(av, bv);
            if ($urandom_range(0, 2) == 0) begin
                wait_done();
            end else begin
                wait_empty();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
